// File: rtl/conv_mac_dp.sv
// Convolution datapath: kernel buffer, 5x5 sliding ifmap window and a two-stage
// 25-tap fixed-point MAC that folds in the DRAM partial sum for write-back.
module conv_mac_dp #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int KNL_WIDTH  = 5,
  parameter int KNL_HEIGHT = 5,
  parameter int KNL_MAXNUM = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  en_ld_knl,
  input  logic                  en_ld_ifmap,
  input  logic [5:0]            num_knls,
  input  logic                  mac_start,
  input  logic [4:0]            knl_sel,
  input  logic                  disable_acc,
  input  logic                  psum_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  output logic [8:0]            knl_cnt,
  output logic                  err
);

  localparam int         TAPS    = KNL_WIDTH * KNL_HEIGHT;
  localparam int         DEPTH   = KNL_MAXNUM * TAPS;
  localparam logic [8:0] DEPTH_C = 9'(DEPTH);

  logic [DATA_WIDTH-1:0]          r_buf [DEPTH];
  logic [DATA_WIDTH-1:0]          r_win [TAPS];
  logic [DATA_WIDTH-1:0]          w_wt  [TAPS];
  logic signed [2*DATA_WIDTH-1:0] w_prod[TAPS];
  logic [DATA_WIDTH-1:0]          w_sum;
  logic [8:0]                     w_base;
  logic                           w_sel_ok;
  logic                           w_knl_ovf;

  logic                  r_v1;
  logic                  r_dis;
  logic [DATA_WIDTH-1:0] r_s;

  assign w_sel_ok  = ({1'b0, knl_sel} < num_knls) && (32'(knl_sel) < KNL_MAXNUM);
  assign w_knl_ovf = en_ld_knl && (knl_cnt == DEPTH_C);

  // Window entry j is column j/KNL_HEIGHT, row j%KNL_HEIGHT; weights are stored row-major.
  always_comb begin
    w_base = w_sel_ok ? 9'(knl_sel) * 9'(TAPS) : 9'd0;
    w_sum  = '0;
    for (int j = 0; j < TAPS; j++) begin
      w_wt[j]   = r_buf[w_base + 9'((j % KNL_HEIGHT) * KNL_WIDTH + (j / KNL_HEIGHT))];
      w_prod[j] = $signed(r_win[j]) * $signed(w_wt[j]);
      w_sum     = w_sum + DATA_WIDTH'(w_prod[j] >>> FRAC_BITS);
    end
    if (!w_sel_ok) begin
      w_sum = '0;
    end else begin
      w_sum = w_sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
      knl_cnt <= 9'd0;
    end else if (en_ld_knl) begin
      if (!w_knl_ovf) begin
        r_buf[knl_cnt] <= data_in;
        knl_cnt        <= knl_cnt + 9'd1;
      end
    end else begin
      knl_cnt <= 9'd0;
    end
  end

  // Newest pixel enters at the top; a 5-pixel reload drops the oldest column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) r_win[i] <= '0;
    end else if (en_ld_ifmap) begin
      for (int i = 0; i < TAPS - 1; i++) r_win[i] <= r_win[i+1];
      r_win[TAPS-1] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1      <= 1'b0;
      r_dis     <= 1'b0;
      r_s       <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      r_v1 <= mac_start;
      if (mac_start) begin
        r_s   <= w_sum;
        r_dis <= disable_acc;
      end
      out_valid <= r_v1;
      if (r_v1) begin
        if (psum_valid && !r_dis) data_out <= r_s + data_in;
        else                      data_out <= r_s;
      end
    end
  end

  // Sticky: kernel overflow, bad kernel select, or missing partial sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (w_knl_ovf || (mac_start && !w_sel_ok) || (r_v1 && !psum_valid)) begin
      err <= 1'b1;
    end
  end

endmodule
